// File: rtl/vga_timing_gen.sv
// Raster timing generator: one H+V counter pair with registered blank/sync aligned to the
// counts, decoded line/frame strobes, a wrapping frame counter and a programmable line hit.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_W-1:0]   line_match,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hblnk,
  output logic               vblnk,
  output logic               hsync,
  output logic               vsync,
  output logic               end_of_line,
  output logic               end_of_frame,
  output logic               line_hit,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam longint unsigned CntLim = 64'd1 << CNT_W;

  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_zero
    $error("vga_timing_gen: ACTIVE and SYNC widths must be non-zero");
  end
  if ((longint'(H_TOT) - 1) >= CntLim || (longint'(V_TOT) - 1) >= CntLim) begin : g_bad_width
    $error("vga_timing_gen: H_TOT-1 or V_TOT-1 does not fit in CNT_W");
  end

  localparam logic [CNT_W-1:0] HMax     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] VMax     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] HActive  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HsStart  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HsEnd    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VsStart  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VsEnd    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               h_wrap, v_wrap;

  assign h_wrap = (hcount_q == HMax);
  assign v_wrap = (vcount_q == VMax);

  // Blank/sync are derived from the next counts so they line up with the counts they describe.
  always_comb begin
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    frame_cnt_d = frame_cnt_q;
    hblnk_d     = hblnk_q;
    vblnk_d     = vblnk_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    if (en) begin
      hcount_d = h_wrap ? '0 : hcount_q + 1'b1;
      if (h_wrap) begin
        vcount_d = v_wrap ? '0 : vcount_q + 1'b1;
      end
      if (h_wrap && v_wrap) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      hblnk_d = (hcount_d >= HActive);
      vblnk_d = (vcount_d >= VActive);
      hsync_d = (hcount_d >= HsStart && hcount_d <= HsEnd) ? H_SYNC_POL : ~H_SYNC_POL;
      vsync_d = (vcount_d >= VsStart && vcount_d <= VsEnd) ? V_SYNC_POL : ~V_SYNC_POL;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      frame_cnt_q <= '0;
      hblnk_q     <= 1'b0;
      vblnk_q     <= 1'b0;
      hsync_q     <= ~H_SYNC_POL;
      vsync_q     <= ~V_SYNC_POL;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      frame_cnt_q <= frame_cnt_d;
      hblnk_q     <= hblnk_d;
      vblnk_q     <= vblnk_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign hcount       = hcount_q;
  assign vcount       = vcount_q;
  assign frame_cnt    = frame_cnt_q;
  assign hblnk        = hblnk_q;
  assign vblnk        = vblnk_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign end_of_line  = h_wrap;
  assign end_of_frame = h_wrap && v_wrap;
  assign line_hit     = (hcount_q == '0) && (vcount_q == line_match);

endmodule
